// File: rtl/seg_decoder.sv
// Seven-segment display decoder: synchronizes an asynchronous active-low
// segment pattern, waits for it to hold steady, then turns accepted digit
// patterns into a valid/ready stream with blank, error and overrun status.
module seg_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] SEG,
  input  logic       DREADY,
  output logic [3:0] DIGIT,
  output logic       DVALID,
  output logic       BLANK,
  output logic       ERR,
  output logic       OVERRUN,
  output logic [7:0] ERRCNT
);

  typedef enum logic {SETTLE, LOCKED} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Counter is 0 on the cycle the first new sample is seen, so acceptance
  // fires once STABLE_CYCLES identical samples have been observed.
  localparam logic [7:0] CNT_LAST  = 8'(STABLE_CYCLES - 2);

  logic [6:0] s1, s2, s3;
  logic [6:0] acc;
  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       accept;
  logic       dec_ok;
  logic [3:0] dec_val;
  logic       new_pat, ev_digit, ev_blank, ev_err;

  // Two-flop synchronizer plus one history stage for change detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= SEG_BLANK;
      s2 <= SEG_BLANK;
      s3 <= SEG_BLANK;
    end else begin
      s1 <= SEG;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pattern table lookup on the synchronized sample
  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    case (s2)
      7'h40:   dec_val = 4'd0;
      7'h79:   dec_val = 4'd1;
      7'h24:   dec_val = 4'd2;
      7'h30:   dec_val = 4'd3;
      7'h19:   dec_val = 4'd4;
      7'h12:   dec_val = 4'd5;
      7'h02:   dec_val = 4'd6;
      7'h78:   dec_val = 4'd7;
      7'h00:   dec_val = 4'd8;
      7'h10:   dec_val = 4'd9;
      default: dec_ok  = 1'b0;
    endcase
  end

  // FSM state and stability counter registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= LOCKED;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: count identical samples while settling, relock on stability
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    case (state)
      LOCKED: begin
        if (s2 != acc) begin
          state_nx = SETTLE;
          cnt_nx   = 8'd0;
        end
      end
      SETTLE: begin
        if (s2 == s3) begin
          if (cnt == CNT_LAST) begin
            accept   = 1'b1;
            state_nx = LOCKED;
            cnt_nx   = 8'd0;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end else begin
          cnt_nx = 8'd0;
        end
      end
      default: begin
        state_nx = LOCKED;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // An accepted pattern equal to the previous one is silent
  assign new_pat  = accept && (s2 != acc);
  assign ev_digit = new_pat && dec_ok;
  assign ev_blank = new_pat && (s2 == SEG_BLANK);
  assign ev_err   = new_pat && !dec_ok && (s2 != SEG_BLANK);

  // Output stream, status flags and error counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc     <= SEG_BLANK;
      DIGIT   <= 4'd0;
      DVALID  <= 1'b0;
      BLANK   <= 1'b1;
      ERR     <= 1'b0;
      OVERRUN <= 1'b0;
      ERRCNT  <= 8'd0;
    end else begin
      ERR     <= ev_err;
      OVERRUN <= ev_digit && DVALID && !DREADY;
      if (accept) acc <= s2;
      if (ev_digit) begin
        DIGIT  <= dec_val;
        DVALID <= 1'b1;
        BLANK  <= 1'b0;
      end else if (DVALID && DREADY) begin
        DVALID <= 1'b0;
      end
      if (ev_blank) BLANK <= 1'b1;
      if (ev_err && ERRCNT != 8'hFF) ERRCNT <= ERRCNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_seg_decoder.sv
// Bench for seg_decoder: run-length behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_seg_decoder;
  localparam int S = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [6:0] SEG = 7'h7F;
  logic       DREADY = 1'b0;
  logic [3:0] DIGIT;
  logic       DVALID, BLANK, ERR, OVERRUN;
  logic [7:0] ERRCNT;

  int vecs = 0;
  int errs = 0;

  seg_decoder #(.STABLE_CYCLES(S)) dut (
    .CLK(CLK), .RST_N(RST_N), .SEG(SEG), .DREADY(DREADY),
    .DIGIT(DIGIT), .DVALID(DVALID), .BLANK(BLANK), .ERR(ERR),
    .OVERRUN(OVERRUN), .ERRCNT(ERRCNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int dec(input logic [6:0] p);
    logic [6:0] t [0:9];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    for (int i = 0; i < 10; i++) if (t[i] == p) return i;
    return -1;
  endfunction

  // Model: the value seen by the decoder is SEG delayed two edges; a change
  // from the accepted pattern starts a run, and a run of S identical
  // samples is accepted on the following edge.
  logic [6:0] ms1, ms2, acc, prev, x;
  bit         pend;
  int         run, m_digit, m_cnt, d;
  bit         m_dv, m_blank, m_err, m_ovr, took_digit;

  always @(posedge CLK) begin
    if (!RST_N) begin
      ms1 = 7'h7F; ms2 = 7'h7F; acc = 7'h7F; prev = 7'h7F;
      pend = 0; run = 0; m_digit = 0; m_cnt = 0;
      m_dv = 0; m_blank = 1; m_err = 0; m_ovr = 0;
    end else begin
      x = ms2;
      m_err = 0; m_ovr = 0; took_digit = 0;
      if (!pend) begin
        if (x != acc) begin pend = 1; run = 1; end
      end else begin
        run = (x == prev) ? run + 1 : 1;
        if (run == S) begin
          pend = 0;
          if (x != acc) begin
            d = dec(x);
            if (d >= 0) begin
              if (m_dv && !DREADY) m_ovr = 1;
              m_digit = d; m_dv = 1; m_blank = 0; took_digit = 1;
            end else if (x == 7'h7F) begin
              m_blank = 1;
            end else begin
              m_err = 1;
              if (m_cnt < 255) m_cnt++;
            end
          end
          acc = x;
        end
      end
      if (!took_digit && m_dv && DREADY) m_dv = 0;
      prev = x; ms2 = ms1; ms1 = SEG;
    end
    #1;
    if (RST_N) begin
      chk("cyc_digit", DIGIT, m_digit);
      chk("cyc_dvalid", DVALID, m_dv);
      chk("cyc_blank", BLANK, m_blank);
      chk("cyc_err", ERR, m_err);
      chk("cyc_overrun", OVERRUN, m_ovr);
      chk("cyc_errcnt", ERRCNT, m_cnt);
    end
  end

  task automatic wn(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int c;
    wn(3);
    chk("rst_digit", DIGIT, 0);
    chk("rst_dvalid", DVALID, 0);
    chk("rst_blank", BLANK, 1);
    chk("rst_err", ERR, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_errcnt", ERRCNT, 0);
    RST_N = 1'b1;
    wn(4);

    // digit 3: DVALID rises on edge S+2 counted from first sampling edge
    SEG = 7'h30;
    repeat (S + 1) @(posedge CLK);
    #1 chk("d3_before", DVALID, 0);
    @(posedge CLK);
    #1 chk("d3_dvalid", DVALID, 1);
    chk("d3_digit", DIGIT, 3);
    @(negedge CLK) DREADY = 1'b1;
    @(posedge CLK);
    #1 chk("d3_consumed", DVALID, 0);
    @(negedge CLK) DREADY = 1'b0;

    // short glitch returning to the accepted pattern is silent
    wn(3);
    SEG = 7'h24; wn(3);
    SEG = 7'h30; wn(12);
    chk("glitch_dvalid", DVALID, 0);
    chk("glitch_errcnt", ERRCNT, 0);

    // invalid pattern: single ERR pulse
    SEG = 7'h2A;
    c = 0;
    for (int i = 0; i < 12; i++) begin @(negedge CLK); c += ERR; end
    chk("inv_pulses", c, 1);
    chk("inv_errcnt", ERRCNT, 1);
    for (int i = 0; i < 300; i++) begin
      SEG = (i % 2 == 0) ? 7'h2B : 7'h2A;
      wn(S + 3);
    end
    chk("errcnt_sat", ERRCNT, 255);

    // overrun: 7 pending, 8 replaces it
    SEG = 7'h78; wn(10);
    chk("ovr_d7", DIGIT, 7);
    SEG = 7'h00;
    c = 0;
    for (int i = 0; i < 12; i++) begin @(negedge CLK); c += OVERRUN; end
    chk("ovr_pulses", c, 1);
    chk("ovr_d8", DIGIT, 8);
    chk("ovr_dvalid", DVALID, 1);

    // blank after 5 keeps DIGIT
    DREADY = 1'b1; wn(1); DREADY = 1'b0;
    SEG = 7'h12; wn(10);
    chk("b_d5_blank", BLANK, 0);
    SEG = 7'h7F; wn(10);
    chk("b_blank", BLANK, 1);
    chk("b_digit", DIGIT, 5);

    // random patterns and hold lengths, random consumer
    for (int k = 0; k < 400; k++) begin
      int r, h;
      r = $urandom_range(0, 11);
      case (r)
        0: SEG = 7'h40;  1: SEG = 7'h79;  2: SEG = 7'h24;  3: SEG = 7'h30;
        4: SEG = 7'h19;  5: SEG = 7'h12;  6: SEG = 7'h02;  7: SEG = 7'h78;
        8: SEG = 7'h00;  9: SEG = 7'h10; 10: SEG = 7'h7F;
        default: SEG = 7'($urandom);
      endcase
      h = $urandom_range(1, 8);
      for (int j = 0; j < h; j++) begin
        DREADY = ($urandom_range(0, 3) == 0);
        wn(1);
      end
    end

    // asynchronous reset with a digit pending
    DREADY = 1'b0;
    SEG = 7'h40; wn(10);
    SEG = 7'h79; wn(10);
    chk("pre_rst_dvalid", DVALID, 1);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    SEG = 7'h7F;
    #1;
    chk("arst_dvalid", DVALID, 0);
    chk("arst_blank", BLANK, 1);
    chk("arst_digit", DIGIT, 0);
    wn(3);
    RST_N = 1'b1;
    wn(20);
    chk("post_rst_dvalid", DVALID, 0);
    chk("post_rst_errcnt", ERRCNT, 0);
    chk("post_rst_blank", BLANK, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
